// File: rtl/dds_phase_addr_gen.sv
// dds_phase_addr_gen: DDS phase accumulator driving a sine ROM address, with
// wrap-synchronous config updates and valid/sync delayed to match ROM read data.
module dds_phase_addr_gen #(
  parameter int PHASE_WIDTH = 32,
  parameter int ADDR_WIDTH  = 10,
  parameter int ROM_LATENCY = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic                   clr,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic [PHASE_WIDTH-1:0] cfg_ftw,
  input  logic [PHASE_WIDTH-1:0] cfg_pofs,
  output logic [ADDR_WIDTH-1:0]  rom_addr,
  output logic                   data_valid,
  output logic                   cycle_sync
);
  localparam int PW = PHASE_WIDTH;
  localparam int AW = ADDR_WIDTH;
  localparam int L  = ROM_LATENCY;
  typedef enum logic [1:0] {IDLE, RUN, PEND} state_t;
  state_t state, state_nx;
  logic [PW-1:0] acc, ftw_r, pofs_r, pend_ftw, pend_pofs;
  logic [PW:0] sum;
  logic [AW-1:0] addr_nx;
  logic pending, pend_nx, sync_flag, wrap, cap, app, issue;
  logic [L:0] vld_pipe, sync_pipe;
  assign sum       = {1'b0, acc} + {1'b0, ftw_r};
  assign wrap      = sum[PW];
  assign addr_nx   = AW'((acc + pofs_r) >> (PW - AW));
  assign cap       = cfg_valid && !pending;
  assign issue     = en && !clr;
  assign cfg_ready = !pending;
  always_comb begin
    app      = 1'b0;
    pend_nx  = pending;
    state_nx = state;
    app      = pending && (clr || state == IDLE ||
               (state == PEND && en && (wrap || ftw_r == '0)));
    pend_nx  = cap || (pending && !app);
    // clr parks in IDLE so a config captured alongside it applies on the next edge
    state_nx = (clr || !en) ? IDLE : pend_nx ? PEND : RUN;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pending   <= 1'b0;
      acc       <= '0;
      ftw_r     <= '0;
      pofs_r    <= '0;
      pend_ftw  <= '0;
      pend_pofs <= '0;
      rom_addr  <= '0;
      sync_flag <= 1'b1;
      vld_pipe  <= '0;
      sync_pipe <= '0;
    end else begin
      state   <= state_nx;
      pending <= pend_nx;
      if (cap) begin
        pend_ftw  <= cfg_ftw;
        pend_pofs <= cfg_pofs;
      end
      if (app) begin
        ftw_r  <= pend_ftw;
        pofs_r <= pend_pofs;
      end
      if (clr) begin
        acc       <= '0;
        sync_flag <= 1'b1;
      end else if (en) begin
        acc       <= sum[PW-1:0];
        rom_addr  <= addr_nx;
        sync_flag <= wrap;
      end
      vld_pipe  <= {vld_pipe[L-1:0], issue};
      sync_pipe <= {sync_pipe[L-1:0], issue && sync_flag};
    end
  end
  assign data_valid = vld_pipe[L];
  assign cycle_sync = sync_pipe[L];
endmodule

// File: tb/tb_dds_phase_addr_gen.sv
// tb_dds_phase_addr_gen: checks two DDS instances (ROM latency 1 and 2) against
// a behavioural phase/sample model under directed and random stimulus.
module tb_dds_phase_addr_gen;
  logic clk = 0, rst_n = 1, en = 0, clr = 0, cfg_valid = 0;
  logic [31:0] cfg_ftw = 0, cfg_pofs = 0;
  logic rdy1, rdy2, dv1, dv2, cs1, cs2;
  logic [9:0] a1, a2;
  int errs = 0, checks = 0;
  logic [31:0] m_acc, m_ftw, m_pofs, m_pftw, m_ppofs;
  logic [9:0] m_addr;
  bit m_pend, m_flag, m_idle;
  bit [1:0] hist [0:4];
  always #5 clk = ~clk;
  dds_phase_addr_gen #(.PHASE_WIDTH(32), .ADDR_WIDTH(10), .ROM_LATENCY(1)) u1 (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .cfg_valid(cfg_valid), .cfg_ready(rdy1),
    .cfg_ftw(cfg_ftw), .cfg_pofs(cfg_pofs), .rom_addr(a1), .data_valid(dv1), .cycle_sync(cs1));
  dds_phase_addr_gen #(.PHASE_WIDTH(32), .ADDR_WIDTH(10), .ROM_LATENCY(2)) u2 (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .cfg_valid(cfg_valid), .cfg_ready(rdy2),
    .cfg_ftw(cfg_ftw), .cfg_pofs(cfg_pofs), .rom_addr(a2), .data_valid(dv2), .cycle_sync(cs2));
  wire [25:0] obs = {a1, dv1, cs1, rdy1, a2, dv2, cs2, rdy2};
  localparam logic [25:0] RST_VEC = {10'd0, 2'b00, 1'b1, 10'd0, 2'b00, 1'b1};
  function automatic logic [25:0] expv();
    return {m_addr, hist[1], !m_pend, m_addr, hist[2], !m_pend};
  endfunction
  task automatic model_reset();
    m_acc = 0; m_ftw = 0; m_pofs = 0; m_pftw = 0; m_ppofs = 0; m_addr = 0;
    m_pend = 0; m_flag = 1; m_idle = 1;
    for (int i = 0; i < 5; i++) hist[i] = 0;
  endtask
  // One clock edge of the reference: sample issue, phase step, config rules.
  task automatic model_edge();
    logic [32:0] s;
    logic [31:0] p;
    bit wrap, cap, app, iss;
    s = {1'b0, m_acc} + {1'b0, m_ftw};
    wrap = s[32];
    cap = cfg_valid && !m_pend;
    app = m_pend && (clr || m_idle || (en && (wrap || m_ftw == 0)));
    iss = en && !clr;
    for (int i = 4; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = {iss, iss & m_flag};
    if (clr) begin
      m_acc = 0; m_flag = 1;
    end else if (en) begin
      p = m_acc + m_pofs;
      m_addr = p[31:22];
      m_flag = wrap;
      m_acc = s[31:0];
    end
    if (app) begin m_ftw = m_pftw; m_pofs = m_ppofs; m_pend = 0; end
    if (cap) begin m_pftw = cfg_ftw; m_ppofs = cfg_pofs; m_pend = 1; end
    m_idle = !en || clr;
  endtask
  task automatic step();
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
  endtask
  task automatic send_cfg(input logic [31:0] f, input logic [31:0] p);
    cfg_valid = 1; cfg_ftw = f; cfg_pofs = p;
    step();
    cfg_valid = 0;
  endtask
  task automatic test_reset();
    #1 rst_n = 0;
    model_reset();
    step(); step();
    checks++;
    if (obs !== RST_VEC) begin errs++; $display("FAIL reset_state got=%h exp=%h", obs, RST_VEC); end
    rst_n = 1;
    step();
    checks++;
    if (obs !== expv()) begin errs++; $display("FAIL reset_idle got=%h exp=%h", obs, expv()); end
  endtask
  task automatic test_basic();
    send_cfg(32'h0040_0000, 0);
    step();
    checks++;
    if (rdy1 !== 1'b1) begin errs++; $display("FAIL basic_ready got=%b exp=1", rdy1); end
    en = 1;
    for (int k = 1; k <= 1100; k++) begin
      step();
      checks++;
      if (obs !== expv()) begin errs++; $display("FAIL basic k=%0d got=%h exp=%h", k, obs, expv()); end
      if (k <= 5) begin
        checks++;
        if (a1 !== 10'(k - 1)) begin errs++; $display("FAIL basic_addr k=%0d got=%0d exp=%0d", k, a1, k - 1); end
      end
      if (k == 1 || k == 2 || k == 3 || k == 1025 || k == 1026) begin
        checks++;
        if ({dv1, cs1, dv2, cs2} !== (k == 1 ? 4'b0000 : k == 2 ? 4'b1100 : k == 3 ? 4'b1011 :
                                      k == 1025 ? 4'b1010 : 4'b1110))
          begin errs++; $display("FAIL basic_vs k=%0d got=%b%b%b%b", k, dv1, cs1, dv2, cs2); end
      end
    end
  endtask
  task automatic test_ftw_change();
    int n;
    for (n = 0; n < 2000 && m_addr != 10'd500; n++) begin
      step();
      checks++;
      if (obs !== expv()) begin errs++; $display("FAIL ftwc_wait got=%h exp=%h", obs, expv()); end
    end
    checks++;
    if (a1 !== 10'd500) begin errs++; $display("FAIL ftwc_reach got=%0d exp=500", a1); end
    send_cfg(32'h0080_0000, 0);
    checks++;
    if (rdy1 !== 1'b0) begin errs++; $display("FAIL ftwc_busy got=%b exp=0", rdy1); end
    for (n = 0; n < 1000 && rdy1 !== 1'b1; n++) begin
      step();
      checks++;
      if (obs !== expv()) begin errs++; $display("FAIL ftwc_pend got=%h exp=%h", obs, expv()); end
    end
    checks++;
    if (a1 !== 10'd1023 || rdy1 !== 1'b1) begin errs++; $display("FAIL ftwc_apply got=%0d/%b exp=1023/1", a1, rdy1); end
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if (a1 !== 10'(2 * k)) begin errs++; $display("FAIL ftwc_step got=%0d exp=%0d", a1, 2 * k); end
    end
  endtask
  task automatic test_pofs_idle();
    en = 0; clr = 1;
    step();
    clr = 0;
    send_cfg(32'h0040_0000, 32'h8000_0000);
    step();
    en = 1;
    step();
    checks++;
    if (a1 !== 10'd512) begin errs++; $display("FAIL pofs_first got=%0d exp=512", a1); end
    for (int k = 0; k < 1100; k++) begin
      step();
      checks++;
      if (obs !== expv()) begin errs++; $display("FAIL pofs k=%0d got=%h exp=%h", k, obs, expv()); end
    end
  endtask
  task automatic test_ftw_zero();
    logic [9:0] a;
    en = 0;
    send_cfg(0, 0);
    step();
    clr = 1;
    step();
    clr = 0; en = 1;
    repeat (3) step();
    checks++;
    if (a1 !== 10'd0 || obs !== expv()) begin errs++; $display("FAIL zero_hold got=%h exp=%h", obs, expv()); end
    send_cfg(32'h0100_0000, 0);
    checks++;
    if (rdy1 !== 1'b0) begin errs++; $display("FAIL zero_busy got=%b exp=0", rdy1); end
    step();
    checks++;
    if (rdy1 !== 1'b1) begin errs++; $display("FAIL zero_apply got=%b exp=1", rdy1); end
    step(); step();
    a = a1;
    step();
    checks++;
    if (a1 !== a + 10'd4 || obs !== expv()) begin errs++; $display("FAIL zero_step got=%0d exp=%0d", a1, a + 10'd4); end
  endtask
  task automatic test_clr();
    en = 0;
    send_cfg(32'h0040_0000, 0);
    step();
    clr = 1;
    step();
    clr = 0; en = 1;
    for (int n = 0; n < 400 && m_addr != 10'd300; n++) begin
      step();
      checks++;
      if (obs !== expv()) begin errs++; $display("FAIL clr_run got=%h exp=%h", obs, expv()); end
    end
    clr = 1;
    step();
    clr = 0;
    checks++;
    if (a1 !== 10'd300) begin errs++; $display("FAIL clr_hold got=%0d exp=300", a1); end
    step();
    checks++;
    if (a1 !== 10'd0) begin errs++; $display("FAIL clr_addr got=%0d exp=0", a1); end
    step();
    checks++;
    if ({dv1, cs1} !== 2'b11 || obs !== expv()) begin errs++; $display("FAIL clr_sync got=%b%b exp=11", dv1, cs1); end
    repeat (7) step();
    en = 0; clr = 1;
    step();
    clr = 0; en = 1;
    step();
    checks++;
    if (a1 !== 10'd0 || obs !== expv()) begin errs++; $display("FAIL clr_idle got=%0d exp=0", a1); end
  endtask
  task automatic test_reset_mid();
    repeat (20) step();
    checks++;
    if (dv2 !== 1'b1) begin errs++; $display("FAIL rstm_pre got=%b exp=1", dv2); end
    rst_n = 0;
    #1;
    checks++;
    if (obs !== RST_VEC) begin errs++; $display("FAIL rstm_async got=%h exp=%h", obs, RST_VEC); end
    model_reset();
    en = 0;
    step();
    rst_n = 1;
    send_cfg(32'h0040_0000, 0);
    step();
    en = 1;
    for (int k = 1; k <= 6; k++) begin
      step();
      checks++;
      if (a2 !== 10'(k - 1) || dv2 !== (k >= 3) || cs2 !== (k == 3) || obs !== expv())
        begin errs++; $display("FAIL rstm_restart k=%0d got=%h exp=%h", k, obs, expv()); end
    end
  endtask
  task automatic test_random();
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(31) == 0) en = ~en;
      clr = ($urandom_range(63) == 0);
      cfg_valid = ($urandom_range(7) == 0);
      cfg_ftw = ($urandom_range(3) == 0) ? 32'h0 : $urandom;
      cfg_pofs = $urandom;
      step();
      checks++;
      if (obs !== expv()) begin errs++; $display("FAIL random k=%0d got=%h exp=%h", k, obs, expv()); end
    end
    clr = 0; cfg_valid = 0;
  endtask
  initial begin
    test_reset();
    test_basic();
    test_ftw_change();
    test_pofs_idle();
    test_ftw_zero();
    test_clr();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
